multi_dispatch: RTL and testbench
=================================

Name: multi_dispatch

Overview:
- Operand-side front end for the shift-add multiplier. Buffers incoming (A,B) operand pairs in a small FIFO.
- Sequences them into the multiplier one at a time: pulses the multiplier's i_valid only when it reports ready, then waits for its o_valid before issuing the next pair.
- Decouples the producer's valid/ready stream from the multiplier's multi-cycle operation.

Parameters:
- WIDTH, 4, operand width; matches multiplier WIDTH
- DEPTH, 4, FIFO entries; power of two, >= 2
- TIMEOUT, 64, watchdog cycle limit (used only with the optional feature)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  producer has operand pair
- s_ready  output  1  FIFO can accept; equals !full
- s_A  input  WIDTH  producer operand A
- s_B  input  WIDTH  producer operand B
- mul_A  output  WIDTH  operand A to multiplier (registered)
- mul_B  output  WIDTH  operand B to multiplier (registered)
- mul_i_valid  output  1  start pulse to multiplier (registered)
- mul_ready  input  1  multiplier idle/ready
- mul_o_valid  input  1  multiplier result-valid pulse
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- busy  output  1  high in ISSUE or WAIT

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge):
  - FIFO pointers and level go to 0; state goes to IDLE.
  - mul_i_valid=0, mul_A=0, mul_B=0, busy=0, s_ready=1.
  - Reset mid-operation discards queued and in-flight work. The multiplier must be reset in the same cycle by the system.
- Push: on s_valid && s_ready, {s_A,s_B} is written at wr_ptr and wr_ptr increments, wrapping at DEPTH.
  - When full, s_ready=0 and pushes are ignored, even if a pop occurs in the same cycle (no pass-through when full).
- Pop: occurs only on the IDLE->ISSUE transition, in the same cycle as the head pair is registered into mul_A/mul_B.
- Simultaneous push and pop: level is unchanged; both pointers advance.
- Pushing into an empty FIFO does not bypass; the earliest issue is the following cycle.
- FSM:
  - IDLE: if level!=0 && mul_ready, register head into mul_A/mul_B, set mul_i_valid=1, pop, go to ISSUE. Otherwise stay.
  - ISSUE (exactly 1 cycle): mul_i_valid=1. Next edge: mul_i_valid=0, go to WAIT.
  - WAIT: hold mul_A/mul_B stable. On mul_o_valid=1, go to IDLE.
  - A mul_o_valid seen during ISSUE or IDLE is ignored (protocol error, no state change).
- Issue rate: at most one operation per multiplier completion, plus 2 cycles (ISSUE, then IDLE re-check).
- mul_A/mul_B change only on IDLE->ISSUE.
- busy = (state != IDLE).
- level range is 0..DEPTH. Pointer wrap uses an extra MSB for the full/empty distinction.

Optional Feature:
- Macro: MULTI_DISPATCH_TIMEOUT_EN.
- Defined:
  - Adds output port timeout_err (1 bit, reset 0) and an internal cycle counter.
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mul_o_valid: timeout_err is set (sticky until rst) and the FSM returns to IDLE. The popped pair is dropped.
- Undefined: no port, no counter; WAIT persists indefinitely.

Test Plan:
- Reset, then idle: rst high 2 cycles, mul_ready=1 -> s_ready=1, level=0, mul_i_valid=0, busy=0 for 10 cycles.
- Single op: push A=3,B=5, with the multiplier model asserting mul_o_valid 6 cycles after the start pulse -> mul_i_valid high exactly one cycle, with mul_A=3, mul_B=5; busy falls the cycle after mul_o_valid; level returns to 0.
- Fill to full: mul_ready=0, push 5 pairs (1,1),(2,2),(3,3),(4,4),(5,5) -> first 4 accepted, level=4, s_ready=0, 5th ignored. Release mul_ready -> issues in order 1,2,3,4, each waiting for its mul_o_valid.
- Simultaneous push/pop: level=2 in IDLE, mul_ready=1, s_valid=1 same cycle -> level stays 2, head advances, new pair appended at tail.
- Reset mid-op: queue 3 pairs, assert rst during WAIT -> next cycle level=0, state IDLE, mul_i_valid=0; no further issues without new pushes.
- (with MULTI_DISPATCH_TIMEOUT_EN, TIMEOUT=8) issue one op, never assert mul_o_valid -> timeout_err=1 after 8 WAIT cycles, busy=0, next queued pair issues.

Source files
------------

// File: rtl/multi_dispatch.sv
// multi_dispatch: operand-side front end for the shift-add multiplier.
//
// Buffers (A,B) operand pairs from a valid/ready producer in a small FIFO and
// feeds them to the multiplier one at a time. A pair is issued only when the
// multiplier reports ready. The next pair is not issued until the multiplier
// returns its result-valid pulse.
//
// Parameters:
//   WIDTH   operand width (matches the multiplier)
//   DEPTH   FIFO entries, power of two, >= 2
//   TIMEOUT WAIT-state watchdog limit in cycles (only with the macro below)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s_valid/s_ready  producer handshake; s_ready = !full
//   s_A, s_B         producer operands
//   mul_A, mul_B     registered operands to the multiplier
//   mul_i_valid      registered one-cycle start pulse to the multiplier
//   mul_ready        multiplier idle
//   mul_o_valid      multiplier result-valid pulse
//   level            FIFO occupancy, 0..DEPTH
//   busy             high while an operation is issued or outstanding
//   timeout_err      sticky watchdog flag (only with the macro below)
//
// Optional feature: define MULTI_DISPATCH_TIMEOUT_EN to add the WAIT watchdog
// and the timeout_err output. In the default build WAIT persists until
// mul_o_valid arrives.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no operation outstanding; issue the head pair when possible
// ISSUE   | start pulse is on mul_i_valid (exactly one cycle)
// WAIT    | waiting for mul_o_valid; operands held stable
module multi_dispatch #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_A,
    input  logic [WIDTH-1:0]         s_B,
    output logic [WIDTH-1:0]         mul_A,
    output logic [WIDTH-1:0]         mul_B,
    output logic                     mul_i_valid,
    input  logic                     mul_ready,
    input  logic                     mul_o_valid,
    output logic [$clog2(DEPTH):0]   level,
`ifdef MULTI_DISPATCH_TIMEOUT_EN
    output logic                     timeout_err,
`endif
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [2*WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]       mul_A_q, mul_A_d;
    logic [WIDTH-1:0]       mul_B_q, mul_B_d;
    logic                   mul_i_valid_q, mul_i_valid_d;
    logic [PW-1:0]          level_w;
    logic                   full_w;
    logic                   push_w;
    logic                   pop_w;
    logic [2*WIDTH-1:0]     head_w;

    // Pointers carry one extra MSB, so the difference is the occupancy and
    // full/empty are distinguishable.
    assign level_w = wr_ptr_q - rd_ptr_q;
    assign full_w  = (level_w == PW'(DEPTH));
    assign push_w  = s_valid && !full_w;
    assign head_w  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef MULTI_DISPATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        pop_w         = 1'b0;
        mul_A_d       = mul_A_q;
        mul_B_d       = mul_B_q;
        mul_i_valid_d = 1'b0;
`ifdef MULTI_DISPATCH_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((level_w != '0) && mul_ready) begin
                    pop_w         = 1'b1;
                    mul_A_d       = head_w[2*WIDTH-1:WIDTH];
                    mul_B_d       = head_w[WIDTH-1:0];
                    mul_i_valid_d = 1'b1;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef MULTI_DISPATCH_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (mul_o_valid) begin
                    state_d = ST_IDLE;
                end
`ifdef MULTI_DISPATCH_TIMEOUT_EN
                // Count WAIT cycles; the TIMEOUT-th one gives up and drops
                // the outstanding pair.
                else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mul_A_q       <= '0;
            mul_B_q       <= '0;
            mul_i_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mul_A_q       <= mul_A_d;
            mul_B_q       <= mul_B_d;
            mul_i_valid_q <= mul_i_valid_d;
            if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_w) mem_q[wr_ptr_q[AW-1:0]] <= {s_A, s_B};
    end

`ifdef MULTI_DISPATCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign s_ready     = !full_w;
    assign level       = level_w;
    assign mul_A       = mul_A_q;
    assign mul_B       = mul_B_q;
    assign mul_i_valid = mul_i_valid_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_dispatch.sv
module tb_multi_dispatch;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_A, s_B;
    logic [WIDTH-1:0] mul_A, mul_B;
    logic             mul_i_valid;
    logic             mul_ready;
    logic             mul_o_valid;
    logic [2:0]       level;
    logic             busy;
`ifdef MULTI_DISPATCH_TIMEOUT_EN
    logic             timeout_err;
`endif

    multi_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_A         (s_A),
        .s_B         (s_B),
        .mul_A       (mul_A),
        .mul_B       (mul_B),
        .mul_i_valid (mul_i_valid),
        .mul_ready   (mul_ready),
        .mul_o_valid (mul_o_valid),
        .level       (level),
`ifdef MULTI_DISPATCH_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Multiplier model: result-valid pulse 6 cycles after the start pulse.
    // Also logs every issued pair and the longest mul_i_valid run.
    logic [7:0] issued_q[$];
    bit         model_en = 1'b1;
    int         iv_run = 0;
    int         iv_max_run = 0;

    initial begin
        int cnt;
        cnt = 0;
        mul_o_valid = 1'b0;
        forever begin
            @(negedge clk);
            mul_o_valid = 1'b0;
            if (!model_en) begin
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mul_o_valid = 1'b1;
            end
            if (mul_i_valid === 1'b1) begin
                issued_q.push_back({mul_A, mul_B});
                if (model_en) cnt = 6;
                iv_run++;
                if (iv_run > iv_max_run) iv_max_run = iv_run;
            end else begin
                iv_run = 0;
            end
        end
    end

    task automatic push(input int a, input int b);
        s_valid = 1'b1;
        s_A     = WIDTH'(a);
        s_B     = WIDTH'(b);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_iv(input string tag);
        int n;
        n = 0;
        while (mul_i_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, int'(mul_i_valid), 1);
    endtask

    task automatic wait_drain(input string tag, input int n_ops);
        int n;
        n = 0;
        while (!(issued_q.size() >= n_ops && busy === 1'b0 && level === 3'd0) && n < 300) begin
            tick();
            n++;
        end
        chk(tag, (n < 300) ? 1 : 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_A       = '0;
        s_B       = '0;
        mul_ready = 1'b1;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mul_A", int'(mul_A), 0);
        chk("rst_mul_B", int'(mul_B), 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_s_ready", int'(s_ready), 1);
            chk("idle_level", int'(level), 0);
            chk("idle_i_valid", int'(mul_i_valid), 0);
            chk("idle_busy", int'(busy), 0);
            tick();
        end

        // Single operation
        issued_q.delete();
        iv_max_run = 0;
        push(3, 5);
        chk("single_level_after_push", int'(level), 1);
        chk("single_no_bypass", int'(mul_i_valid), 0);
        wait_iv("single_issue_seen");
        chk("single_mul_A", int'(mul_A), 3);
        chk("single_mul_B", int'(mul_B), 5);
        chk("single_busy_issue", int'(busy), 1);
        chk("single_level_popped", int'(level), 0);
        tick();
        chk("single_pulse_len", int'(mul_i_valid), 0);
        chk("single_busy_wait", int'(busy), 1);
        begin
            int n;
            n = 0;
            while (mul_o_valid !== 1'b1 && n < 30) begin
                tick();
                n++;
            end
            chk("single_o_valid_seen", int'(mul_o_valid), 1);
            chk("single_wait_cycles", n, 5);
        end
        chk("single_busy_at_o_valid", int'(busy), 1);
        chk("single_hold_A", int'(mul_A), 3);
        tick();
        chk("single_busy_fall", int'(busy), 0);
        chk("single_level_end", int'(level), 0);
        chk("single_issue_count", issued_q.size(), 1);
        chk("single_max_pulse_run", iv_max_run, 1);

        // Fill to full, fifth push ignored, drain in order
        mul_ready = 1'b0;
        issued_q.delete();
        for (int i = 1; i <= 5; i++) begin
            chk("fill_s_ready", int'(s_ready), (i <= 4) ? 1 : 0);
            push(i, i);
        end
        chk("fill_level", int'(level), 4);
        chk("fill_s_ready_full", int'(s_ready), 0);
        chk("fill_busy", int'(busy), 0);
        mul_ready = 1'b1;
        wait_drain("fill_drain_done", 4);
        chk("fill_issue_count", issued_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < issued_q.size()) begin
                chk("fill_order_A", int'(issued_q[k][7:4]), k + 1);
                chk("fill_order_B", int'(issued_q[k][3:0]), k + 1);
            end
        end
        repeat (20) tick();
        chk("fill_fifth_dropped", issued_q.size(), 4);
        chk("fill_level_end", int'(level), 0);

        // Simultaneous push and pop
        mul_ready = 1'b0;
        issued_q.delete();
        push(6, 6);
        push(7, 7);
        chk("simul_level_pre", int'(level), 2);
        mul_ready = 1'b1;
        s_valid   = 1'b1;
        s_A       = 4'd8;
        s_B       = 4'd9;
        tick();
        s_valid = 1'b0;
        chk("simul_level_kept", int'(level), 2);
        chk("simul_busy", int'(busy), 1);
        chk("simul_head_A", int'(mul_A), 6);
        chk("simul_i_valid", int'(mul_i_valid), 1);
        wait_drain("simul_drain_done", 3);
        chk("simul_issue_count", issued_q.size(), 3);
        if (issued_q.size() == 3) begin
            chk("simul_order0", int'(issued_q[0]), 8'h66);
            chk("simul_order1", int'(issued_q[1]), 8'h77);
            chk("simul_order2", int'(issued_q[2]), 8'h89);
        end

        // Reset during WAIT
        mul_ready = 1'b0;
        issued_q.delete();
        push(9, 1);
        push(10, 2);
        push(11, 3);
        mul_ready = 1'b1;
        wait_iv("rmid_issue_seen");
        chk("rmid_mul_A", int'(mul_A), 9);
        tick();
        chk("rmid_busy_wait", int'(busy), 1);
        chk("rmid_level_wait", int'(level), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_level", int'(level), 0);
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_i_valid", int'(mul_i_valid), 0);
        chk("rmid_mul_A", int'(mul_A), 0);
        chk("rmid_s_ready", int'(s_ready), 1);
        repeat (20) tick();
        chk("rmid_no_more_issue", issued_q.size(), 1);
        chk("rmid_busy_end", int'(busy), 0);

`ifdef MULTI_DISPATCH_TIMEOUT_EN
        // Watchdog: multiplier never answers
        model_en  = 1'b0;
        mul_ready = 1'b0;
        issued_q.delete();
        chk("tmo_err_clear", int'(timeout_err), 0);
        push(12, 4);
        push(13, 5);
        mul_ready = 1'b1;
        wait_iv("tmo_issue_seen");
        begin
            int n;
            n = 0;
            while (timeout_err !== 1'b1 && n < 40) begin
                tick();
                n++;
            end
            chk("tmo_err_set", int'(timeout_err), 1);
            chk("tmo_cycles", n, 9);
        end
        chk("tmo_busy", int'(busy), 0);
        chk("tmo_level", int'(level), 1);
        wait_iv("tmo_next_issue");
        chk("tmo_next_A", int'(mul_A), 13);
        chk("tmo_err_sticky", int'(timeout_err), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
